recovery_lock_controller: RTL and testbench
===========================================

# recovery_lock_controller

Sequences the `recovery` datapath through clear, acquisition, lock qualification and supervised lock. It drives `recovery_en_i` and `clear_state_i` of `recovery` and consumes its lock and violation flags. On loss of lock it retries with a back-off interval and declares a fault after too many consecutive failures. It sits between the register/config layer and `recovery`, and gives the generation side a single qualified `lock_valid_o`.

## Interface
- `TIMER_WIDTH`, 16: width of the acquire, stable and back-off timers and their config inputs.
- `CLEAR_WIDTH`, 4: width of the clear-pulse length config.
- `RETRY_WIDTH`, 4: width of the retry counter and retry limit.

- `sys_dom_i` input `common_p::clk_dom_s`: one clock; reset is synchronous and active-low.
- `enable_i` input 1: level; controller runs while high.
- `restart_i` input 1: pulse; forces re-acquisition and clears the retry count.
- `require_full_lock_i` input 1: 1 qualifies on `fully_locked_in_i`; 0 qualifies on `high_locked_in_i`.
- `clear_cycles_i` input CLEAR_WIDTH: length of the `clear_state_o` pulse; 0 is treated as 1.
- `acquire_timeout_i` input TIMER_WIDTH: maximum cycles in ACQUIRE; 0 means no timeout.
- `stable_cycles_i` input TIMER_WIDTH: consecutive lock cycles required in QUALIFY; 0 is treated as 1.
- `backoff_cycles_i` input TIMER_WIDTH: cycles held in BACKOFF; 0 is treated as 1.
- `max_retries_i` input RETRY_WIDTH: consecutive failures allowed before FAULT.
- `fully_locked_in_i`, `high_locked_in_i` input 1 each: from `recovery`.
- `excessive_drift_violation_i` input 1: from `recovery`.
- `bandpass_flags_i` input 4: {high over, high under, low over, low under}; they are ORed internally.
- `recovery_en_o` output 1: to `recovery.recovery_en_i`.
- `clear_state_o` output 1: to `recovery.clear_state_i`.
- `lock_valid_o` output 1: high only in LOCKED.
- `fault_o` output 1: high only in FAULT.
- `relock_event_o` output 1: one-cycle pulse on each LOCKED→BACKOFF exit.
- `state_o` output 3: current state encoding.
- `retry_count_o` output RETRY_WIDTH: consecutive failures since the last LOCKED entry.

## Operation
- State encodings: IDLE=0, CLEAR=1, ACQUIRE=2, QUALIFY=3, LOCKED=4, BACKOFF=5, FAULT=6. The encoding 7 is illegal and recovers to IDLE.
- `lock` means `require_full_lock_i ? fully_locked_in_i : high_locked_in_i`.
- `viol` means `excessive_drift_violation_i | (|bandpass_flags_i)`.
- Priority, highest first:
  1. `~enable_i` → IDLE from any state.
  2. `restart_i` (when not in IDLE) → CLEAR, with the retry count set to 0.
  3. The per-state rules below.
- Per-state rules:
  - IDLE: all outputs 0. `enable_i` → CLEAR, retry count set to 0.
  - CLEAR: `clear_state_o`=1, `recovery_en_o`=0. Stays max(`clear_cycles_i`,1) cycles, then → ACQUIRE. The acquire timer is zeroed on entry.
  - ACQUIRE: `recovery_en_o`=1.
    - `lock` → QUALIFY, stable counter set to 1.
    - Otherwise, if `acquire_timeout_i`≠0 and the acquire timer reaches `acquire_timeout_i` → BACKOFF (failure).
    - The acquire timer saturates and is not reset when returning from QUALIFY.
  - QUALIFY: `recovery_en_o`=1.
    - `~lock` or `viol` → ACQUIRE.
    - When the stable counter reaches max(`stable_cycles_i`,1) with `lock` still high → LOCKED, retry count set to 0.
    - The acquire timeout keeps running in QUALIFY.
  - LOCKED: `recovery_en_o`=1, `lock_valid_o`=1. `~lock` or `viol` → BACKOFF (failure), with `relock_event_o` pulsed in the transition cycle.
  - BACKOFF: `recovery_en_o`=0. Stays max(`backoff_cycles_i`,1) cycles. On the last cycle:
    - retry count > `max_retries_i` → FAULT;
    - else → CLEAR.
  - FAULT: `fault_o`=1, `recovery_en_o`=0. Held until `restart_i` or `~enable_i`.
- Failure accounting: every transition into BACKOFF increments the retry count, saturating at all-ones.
- Timers saturate and never wrap.
- Config inputs are sampled continuously; changing them mid-phase affects only the current compare.

## Timing
- All outputs are registered Moore outputs decoded from the next state, so they change in the same cycle `state_o` changes.
- Input-to-state latency is 1 cycle: a condition sampled at edge N is reflected in `state_o` and the outputs after edge N.
- Reset (`sys_dom_i` reset low at a clock edge):
  - State goes to IDLE; all outputs and counters go to 0.
  - Reset mid-operation drops `recovery_en_o` the next cycle.
- Enable to first enabled cycle: `enable_i` rises at cycle 0 → `clear_state_o` is high for cycles 1..C → `recovery_en_o` is high from cycle C+1 (C = max(`clear_cycles_i`,1)).
- Simultaneous events:
  - `restart_i` together with `~enable_i` → IDLE.
  - `lock` together with timeout expiry in ACQUIRE → QUALIFY.
  - `viol` together with stable count reached → ACQUIRE.
  - `restart_i` in the BACKOFF exit cycle → CLEAR, retry count 0.

## Test plan
- Clean lock:
  - Stimulus: `clear_cycles_i`=3, `stable_cycles_i`=4, `enable_i`↑ at cycle 0, `lock` high from cycle 6.
  - Response: `clear_state_o` high cycles 1–3; `recovery_en_o` high from 4; QUALIFY at 7; LOCKED and `lock_valid_o` at 11; retry count 0.
- Acquire timeout into fault:
  - Stimulus: `acquire_timeout_i`=10, `backoff_cycles_i`=5, `max_retries_i`=2, lock never asserts.
  - Response: three BACKOFF entries; `retry_count_o` 1,2,3; FAULT after the third back-off; `fault_o`=1; `recovery_en_o`=0.
- Lock loss:
  - Stimulus: pulse `excessive_drift_violation_i` for 1 cycle while LOCKED.
  - Response: `relock_event_o` single pulse; BACKOFF; then CLEAR; then re-lock with retry count returned to 0.
- Qualification glitch:
  - Stimulus: `stable_cycles_i`=8; lock drops for 1 cycle at stable count 5.
  - Response: QUALIFY→ACQUIRE→QUALIFY with the count restarted; LOCKED only after 8 unbroken cycles.
- Restart and disable priority:
  - Stimulus: `restart_i` in FAULT; later `enable_i`↓ in the same cycle as `restart_i`.
  - Response: FAULT→CLEAR with retry count 0; then IDLE with all outputs 0.
- Reset mid-operation:
  - Stimulus: assert reset while in LOCKED.
  - Response: next cycle state_o=0 and every output 0.

Source files
------------

// File: rtl/recovery_lock_controller.sv
// Sequences the recovery datapath through clear, acquisition, lock qualification
// and supervised lock, with back-off retries and a fault state on repeated failure.
package common_p;
  typedef struct packed {
    logic clk;
    logic rst_n;
  } clk_dom_s;
endpackage

module recovery_lock_controller #(
  parameter int unsigned TIMER_WIDTH = 16,
  parameter int unsigned CLEAR_WIDTH = 4,
  parameter int unsigned RETRY_WIDTH = 4
) (
  input  common_p::clk_dom_s      sys_dom_i,
  input  logic                    enable_i,
  input  logic                    restart_i,
  input  logic                    require_full_lock_i,
  input  logic [CLEAR_WIDTH-1:0]  clear_cycles_i,
  input  logic [TIMER_WIDTH-1:0]  acquire_timeout_i,
  input  logic [TIMER_WIDTH-1:0]  stable_cycles_i,
  input  logic [TIMER_WIDTH-1:0]  backoff_cycles_i,
  input  logic [RETRY_WIDTH-1:0]  max_retries_i,
  input  logic                    fully_locked_in_i,
  input  logic                    high_locked_in_i,
  input  logic                    excessive_drift_violation_i,
  input  logic [3:0]              bandpass_flags_i,
  output logic                    recovery_en_o,
  output logic                    clear_state_o,
  output logic                    lock_valid_o,
  output logic                    fault_o,
  output logic                    relock_event_o,
  output logic [2:0]              state_o,
  output logic [RETRY_WIDTH-1:0]  retry_count_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_ACQUIRE = 3'd2,
    ST_QUALIFY = 3'd3,
    ST_LOCKED  = 3'd4,
    ST_BACKOFF = 3'd5,
    ST_FAULT   = 3'd6
  } state_e;

  logic clk;
  logic rst_n;
  assign clk   = sys_dom_i.clk;
  assign rst_n = sys_dom_i.rst_n;

  state_e                 state_q, state_d;
  logic [TIMER_WIDTH-1:0] phase_q, phase_d;
  logic [TIMER_WIDTH-1:0] acq_q, acq_d;
  logic [TIMER_WIDTH-1:0] stable_q, stable_d;
  logic [RETRY_WIDTH-1:0] retry_q, retry_d;
  logic recovery_en_q, recovery_en_d;
  logic clear_state_q, clear_state_d;
  logic lock_valid_q, lock_valid_d;
  logic fault_q, fault_d;
  logic relock_event_q, relock_event_d;

  logic                   lock_c;
  logic                   viol_c;
  logic [TIMER_WIDTH-1:0] clear_len_c;
  logic [TIMER_WIDTH-1:0] stable_len_c;
  logic [TIMER_WIDTH-1:0] backoff_len_c;
  logic [TIMER_WIDTH-1:0] phase_inc_c;
  logic [TIMER_WIDTH-1:0] acq_inc_c;
  logic [TIMER_WIDTH-1:0] stable_inc_c;
  logic [RETRY_WIDTH-1:0] retry_inc_c;
  logic                   acq_expired_c;

  // Qualification inputs, clamped config lengths and saturating increments
  always_comb begin
    lock_c        = require_full_lock_i ? fully_locked_in_i : high_locked_in_i;
    viol_c        = excessive_drift_violation_i | (|bandpass_flags_i);
    clear_len_c   = (clear_cycles_i == '0) ? TIMER_WIDTH'(1) : TIMER_WIDTH'(clear_cycles_i);
    stable_len_c  = (stable_cycles_i == '0) ? TIMER_WIDTH'(1) : stable_cycles_i;
    backoff_len_c = (backoff_cycles_i == '0) ? TIMER_WIDTH'(1) : backoff_cycles_i;
    phase_inc_c   = (&phase_q) ? phase_q : phase_q + TIMER_WIDTH'(1);
    acq_inc_c     = (&acq_q) ? acq_q : acq_q + TIMER_WIDTH'(1);
    stable_inc_c  = (&stable_q) ? stable_q : stable_q + TIMER_WIDTH'(1);
    retry_inc_c   = (&retry_q) ? retry_q : retry_q + RETRY_WIDTH'(1);
    // acq_inc_c counts the current cycle, so the limit bounds cycles spent acquiring
    acq_expired_c = (acquire_timeout_i != '0) && (acq_inc_c >= acquire_timeout_i);
  end

  // Next-state, counter and Moore output decode
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    acq_d    = acq_q;
    stable_d = stable_q;
    retry_d  = retry_q;

    if (!enable_i) begin
      state_d = ST_IDLE;
      retry_d = '0;
    end else if (restart_i && (state_q != ST_IDLE)) begin
      state_d = ST_CLEAR;
      retry_d = '0;
      phase_d = TIMER_WIDTH'(1);
      acq_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_CLEAR;
          retry_d = '0;
          phase_d = TIMER_WIDTH'(1);
          acq_d   = '0;
        end
        ST_CLEAR: begin
          acq_d = '0;
          if (phase_q >= clear_len_c) state_d = ST_ACQUIRE;
          else                        phase_d = phase_inc_c;
        end
        ST_ACQUIRE: begin
          acq_d = acq_inc_c;
          if (lock_c) begin
            state_d  = ST_QUALIFY;
            stable_d = TIMER_WIDTH'(1);
          end else if (acq_expired_c) begin
            state_d = ST_BACKOFF;
            phase_d = TIMER_WIDTH'(1);
            retry_d = retry_inc_c;
          end
        end
        ST_QUALIFY: begin
          acq_d = acq_inc_c;
          if (!lock_c || viol_c) begin
            state_d = ST_ACQUIRE;
          end else if (stable_q >= stable_len_c) begin
            state_d = ST_LOCKED;
            retry_d = '0;
          end else begin
            stable_d = stable_inc_c;
          end
        end
        ST_LOCKED: begin
          if (!lock_c || viol_c) begin
            state_d = ST_BACKOFF;
            phase_d = TIMER_WIDTH'(1);
            retry_d = retry_inc_c;
          end
        end
        ST_BACKOFF: begin
          if (phase_q >= backoff_len_c) begin
            if (retry_q > max_retries_i) begin
              state_d = ST_FAULT;
            end else begin
              state_d = ST_CLEAR;
              phase_d = TIMER_WIDTH'(1);
              acq_d   = '0;
            end
          end else begin
            phase_d = phase_inc_c;
          end
        end
        ST_FAULT: ;
        default: begin
          state_d = ST_IDLE;
          retry_d = '0;
        end
      endcase
    end

    recovery_en_d  = (state_d == ST_ACQUIRE) || (state_d == ST_QUALIFY) ||
                     (state_d == ST_LOCKED);
    clear_state_d  = (state_d == ST_CLEAR);
    lock_valid_d   = (state_d == ST_LOCKED);
    fault_d        = (state_d == ST_FAULT);
    relock_event_d = (state_q == ST_LOCKED) && (state_d == ST_BACKOFF);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      phase_q        <= '0;
      acq_q          <= '0;
      stable_q       <= '0;
      retry_q        <= '0;
      recovery_en_q  <= 1'b0;
      clear_state_q  <= 1'b0;
      lock_valid_q   <= 1'b0;
      fault_q        <= 1'b0;
      relock_event_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      acq_q          <= acq_d;
      stable_q       <= stable_d;
      retry_q        <= retry_d;
      recovery_en_q  <= recovery_en_d;
      clear_state_q  <= clear_state_d;
      lock_valid_q   <= lock_valid_d;
      fault_q        <= fault_d;
      relock_event_q <= relock_event_d;
    end
  end

  assign recovery_en_o  = recovery_en_q;
  assign clear_state_o  = clear_state_q;
  assign lock_valid_o   = lock_valid_q;
  assign fault_o        = fault_q;
  assign relock_event_o = relock_event_q;
  assign state_o        = 3'(state_q);
  assign retry_count_o  = retry_q;

endmodule

// File: tb/tb_recovery_lock_controller.sv
// Scoreboard bench for recovery_lock_controller: a cycle-level reference model
// predicts every output; a separate monitor pops and compares each cycle.
module tb_recovery_lock_controller;
  localparam int unsigned TW = 16;
  localparam int unsigned CW = 4;
  localparam int unsigned RW = 4;
  localparam int IDLE = 0, CLEAR = 1, ACQ = 2, QUAL = 3, LOCKED = 4, BACKOFF = 5, FAULT = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  common_p::clk_dom_s dom;
  assign dom = {clk, rst_n};

  logic          enable, restart, req_full, full_lk, high_lk, drift;
  logic [3:0]    bp;
  logic [CW-1:0] clr_cfg;
  logic [TW-1:0] acq_to, stab_cfg, bo_cfg;
  logic [RW-1:0] max_rt;

  logic          recovery_en_o, clear_state_o, lock_valid_o, fault_o, relock_event_o;
  logic [2:0]    state_o;
  logic [RW-1:0] retry_count_o;
  logic [11:0]   dut_vec;
  assign dut_vec = {state_o, recovery_en_o, clear_state_o, lock_valid_o, fault_o,
                    relock_event_o, retry_count_o};

  recovery_lock_controller #(.TIMER_WIDTH(TW), .CLEAR_WIDTH(CW), .RETRY_WIDTH(RW)) dut (
    .sys_dom_i                   (dom),
    .enable_i                    (enable),
    .restart_i                   (restart),
    .require_full_lock_i         (req_full),
    .clear_cycles_i              (clr_cfg),
    .acquire_timeout_i           (acq_to),
    .stable_cycles_i             (stab_cfg),
    .backoff_cycles_i            (bo_cfg),
    .max_retries_i               (max_rt),
    .fully_locked_in_i           (full_lk),
    .high_locked_in_i            (high_lk),
    .excessive_drift_violation_i (drift),
    .bandpass_flags_i            (bp),
    .recovery_en_o               (recovery_en_o),
    .clear_state_o               (clear_state_o),
    .lock_valid_o                (lock_valid_o),
    .fault_o                     (fault_o),
    .relock_event_o              (relock_event_o),
    .state_o                     (state_o),
    .retry_count_o               (retry_count_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  logic [11:0] exp_q[$];

  // Reference model: phase = cycles spent in CLEAR/BACKOFF including the current one,
  // acq = cycles spent acquiring/qualifying, run = consecutive lock cycles seen.
  int m_state = IDLE, m_phase = 0, m_acq = 0, m_run = 0, m_retry = 0;

  task automatic model_step(output logic [11:0] e);
    int ns, c_len, s_len, b_len, elapsed;
    bit lk, vi, relock;
    lk = req_full ? full_lk : high_lk;
    vi = drift | (|bp);
    c_len = (clr_cfg == 0) ? 1 : int'(clr_cfg);
    s_len = (stab_cfg == 0) ? 1 : int'(stab_cfg);
    b_len = (bo_cfg == 0) ? 1 : int'(bo_cfg);
    relock = 1'b0;
    ns = m_state;
    if (!rst_n) begin
      ns = IDLE; m_retry = 0; m_phase = 0; m_acq = 0; m_run = 0;
    end else if (!enable) begin
      ns = IDLE; m_retry = 0;
    end else if (restart && m_state != IDLE) begin
      ns = CLEAR; m_retry = 0; m_phase = 1; m_acq = 0;
    end else begin
      case (m_state)
        IDLE: begin ns = CLEAR; m_retry = 0; m_phase = 1; m_acq = 0; end
        CLEAR: begin
          if (m_phase >= c_len) begin ns = ACQ; m_acq = 0; end
          else m_phase++;
        end
        ACQ: begin
          elapsed = m_acq + 1;
          if (lk) begin ns = QUAL; m_run = 1; end
          else if (acq_to != 0 && elapsed >= int'(acq_to)) begin
            ns = BACKOFF; m_phase = 1; m_retry = (m_retry < 15) ? m_retry + 1 : 15;
          end
          m_acq = (elapsed > 65535) ? 65535 : elapsed;
        end
        QUAL: begin
          elapsed = m_acq + 1;
          m_acq = (elapsed > 65535) ? 65535 : elapsed;
          if (!lk || vi) ns = ACQ;
          else if (m_run >= s_len) begin ns = LOCKED; m_retry = 0; end
          else m_run++;
        end
        LOCKED: begin
          if (!lk || vi) begin
            ns = BACKOFF; m_phase = 1; relock = 1'b1;
            m_retry = (m_retry < 15) ? m_retry + 1 : 15;
          end
        end
        BACKOFF: begin
          if (m_phase >= b_len) begin
            if (m_retry > int'(max_rt)) ns = FAULT;
            else begin ns = CLEAR; m_phase = 1; m_acq = 0; end
          end else m_phase++;
        end
        FAULT: ;
        default: begin ns = IDLE; m_retry = 0; end
      endcase
    end
    m_state = ns;
    e = {3'(ns), ns == ACQ || ns == QUAL || ns == LOCKED, ns == CLEAR, ns == LOCKED,
         ns == FAULT, relock, 4'(m_retry)};
  endtask

  // Issue one clock of stimulus: predict, queue the prediction, advance to the next negedge
  task automatic step();
    logic [11:0] e;
    model_step(e);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: outputs are valid every cycle, compared 1 time unit after the edge
  initial begin
    logic [11:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (dut_vec !== e) begin
          n_mis++;
          $display("FAIL cycle_outputs @%0t: got %03h expected %03h (state %0d/%0d)",
                   $time, dut_vec, e, dut_vec[11:9], e[11:9]);
        end
      end
    end
  end

  task automatic set_cfg(input int c, input int to, input int s, input int b, input int r);
    clr_cfg = CW'(c); acq_to = TW'(to); stab_cfg = TW'(s); bo_cfg = TW'(b); max_rt = RW'(r);
  endtask

  initial begin
    int k, rc;
    bit lk_level;
    enable = 0; restart = 0; req_full = 1; full_lk = 0; high_lk = 0; drift = 0; bp = '0;
    set_cfg(3, 0, 4, 2, 3);
    @(negedge clk);
    repeat (3) step();
    chk("reset_outputs", dut_vec, 0);
    rst_n = 1'b1;

    // Clean lock: enable at cycle 0, lock from cycle 6
    for (int c = 0; c < 14; c++) begin
      enable = 1; full_lk = (c >= 6);
      step();
      k = c + 1;
      chk("clean_clear", clear_state_o, (k >= 1 && k <= 3));
      chk("clean_recovery_en", recovery_en_o, (k >= 4));
      chk("clean_lock_valid", lock_valid_o, (k >= 11));
      if (k == 7)  chk("clean_qualify_entry", state_o, QUAL);
      if (k == 11) chk("clean_locked_entry", state_o, LOCKED);
    end
    chk("clean_retry", retry_count_o, 0);

    // Lock loss: one-cycle drift violation while LOCKED
    rc = 0;
    drift = 1; step(); drift = 0;
    if (relock_event_o) rc++;
    chk("loss_backoff", state_o, BACKOFF);
    chk("loss_retry", retry_count_o, 1);
    for (int c = 0; c < 20; c++) begin
      step();
      if (relock_event_o) rc++;
    end
    chk("loss_relock_pulses", rc, 1);
    chk("loss_relocked", lock_valid_o, 1);
    chk("loss_retry_cleared", retry_count_o, 0);

    // Acquire timeout into fault
    enable = 0; step();
    set_cfg(1, 10, 4, 5, 2); full_lk = 0;
    for (int c = 0; c < 51; c++) begin
      enable = 1;
      step();
      k = c + 1;
      if (k == 12) begin chk("to_bo1_state", state_o, BACKOFF); chk("to_bo1_retry", retry_count_o, 1); end
      if (k == 28) begin chk("to_bo2_state", state_o, BACKOFF); chk("to_bo2_retry", retry_count_o, 2); end
      if (k == 44) begin chk("to_bo3_state", state_o, BACKOFF); chk("to_bo3_retry", retry_count_o, 3); end
      if (k == 48) chk("to_not_yet_fault", fault_o, 0);
      if (k == 49) begin
        chk("to_fault_state", state_o, FAULT);
        chk("to_fault_flag", fault_o, 1);
        chk("to_fault_en", recovery_en_o, 0);
      end
    end
    chk("fault_held", state_o, FAULT);

    // Restart in FAULT, then restart together with disable
    restart = 1; step(); restart = 0;
    chk("restart_state", state_o, CLEAR);
    chk("restart_retry", retry_count_o, 0);
    chk("restart_clear", clear_state_o, 1);
    repeat (3) step();
    enable = 0; restart = 1; step(); restart = 0;
    chk("disable_priority", dut_vec, 0);

    // Qualification glitch: stable=8, lock drops at stable count 5
    set_cfg(1, 0, 8, 2, 3); full_lk = 1;
    for (int c = 0; c < 20; c++) begin
      enable = 1; full_lk = (c != 7);
      step();
      k = c + 1;
      if (k == 8) chk("glitch_back_to_acq", state_o, ACQ);
      if (k == 9) chk("glitch_requalify", state_o, QUAL);
      chk("glitch_lock_valid", lock_valid_o, (k >= 17));
    end

    // Randomized operation with periodic config changes
    lk_level = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 256 == 0) begin
        set_cfg($urandom_range(0, 3), ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 25),
                $urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 3));
        req_full = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 11) == 0) lk_level = ~lk_level;
      full_lk = lk_level ^ ($urandom_range(0, 24) == 0);
      high_lk = lk_level ^ ($urandom_range(0, 19) == 0);
      drift   = ($urandom_range(0, 49) == 0);
      bp      = ($urandom_range(0, 59) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      restart = ($urandom_range(0, 79) == 0);
      enable  = ($urandom_range(0, 149) != 0);
      rst_n   = !(($urandom_range(0, 299) == 0) ||
                  (m_state == LOCKED && $urandom_range(0, 59) == 0));
      step();
    end

    // Reset while LOCKED
    rst_n = 1; enable = 1; restart = 1; drift = 0; bp = '0;
    req_full = 1; full_lk = 1; high_lk = 1;
    set_cfg(1, 0, 2, 1, 3);
    step(); restart = 0;
    for (int i = 0; i < 100 && !lock_valid_o; i++) step();
    chk("reach_locked", lock_valid_o, 1);
    rst_n = 0; step();
    chk("reset_mid_lock", dut_vec, 0);
    rst_n = 1; step();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
